ddr_write_ctrl: RTL and testbench

- Write-direction counterpart of the DDR read path feeding the weight and bias FIFO controllers.
- After a one-cycle `conf` pulse, drains a burst of 512-bit result beats from an upstream write-back FIFO.
- Drives the MIG UI write command and write-data channels (command and data handshakes independent) to store them at consecutive DDR addresses.
- Returns `idle` when every beat has been accepted by the MIG.

---
 rtl/ddr_write_ctrl.sv | 149 ++++++++++++++
 tb/tb_ddr_write_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_write_ctrl.sv
// DDR write controller: drains a burst of 512-bit beats from an upstream write-back FIFO and
// writes them to consecutive DDR addresses through the MIG UI. The command and write-data
// channels run independently. A 2-entry skid buffer absorbs the one-cycle FIFO read latency.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   conf                  start pulse, sampled only while idle
//   ddr_st_addr, ddr_len  byte start address (64-byte aligned) and beat count
//   idle                  high when no transfer is active
//   wr_fifo_*             upstream FIFO read side (data valid the cycle after req)
//   init_calib_complete   MIG calibration done; gates new commands and FIFO reads
//   app_*                 MIG UI write command and write-data channels
module ddr_write_ctrl #(
  parameter int unsigned APP_DATA_WIDTH = 512,
  parameter int unsigned APP_ADDR_WIDTH = 29,
  parameter int unsigned DDR_ADDR_LEN   = 32,
  parameter int unsigned SINGLE_LEN     = 24,
  parameter int unsigned DM_WIDTH       = 8,
  parameter int unsigned APP_CMD_WIDTH  = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 conf,
  input  logic [DDR_ADDR_LEN-1:0]              ddr_st_addr,
  input  logic [SINGLE_LEN-1:0]                ddr_len,
  output logic                                 idle,
  input  logic                                 wr_fifo_empty,
  output logic                                 wr_fifo_req,
  input  logic [APP_DATA_WIDTH-1:0]            wr_fifo_data,
  input  logic                                 init_calib_complete,
  input  logic                                 app_rdy,
  input  logic                                 app_wdf_rdy,
  output logic [APP_CMD_WIDTH-1:0]             app_cmd,
  output logic [APP_ADDR_WIDTH-1:0]            app_addr,
  output logic                                 app_en,
  output logic [APP_DATA_WIDTH/DM_WIDTH-1:0]   app_wdf_mask,
  output logic [APP_DATA_WIDTH-1:0]            app_wdf_data,
  output logic                                 app_wdf_end,
  output logic                                 app_wdf_wren
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                    state_q, state_d;
  logic [SINGLE_LEN-1:0]     len_q, len_d;
  logic [SINGLE_LEN-1:0]     req_cnt_q, req_cnt_d;
  logic [SINGLE_LEN-1:0]     cmd_cnt_q, cmd_cnt_d;
  logic [SINGLE_LEN-1:0]     dat_cnt_q, dat_cnt_d;
  logic [APP_ADDR_WIDTH-1:0] base_q, base_d;
  logic                      pend_q, pend_d;   // FIFO read issued last cycle, data arrives now
  logic                      rd_ptr_q, rd_ptr_d;
  logic                      wr_ptr_q, wr_ptr_d;
  logic [1:0]                occ_q, occ_d;
  logic [APP_DATA_WIDTH-1:0] buf_q [2];

  logic       run, start, push, pop, cmd_fire;
  logic [1:0] fill;

  assign run      = (state_q == StRun);
  assign start    = (state_q == StIdle) && conf && (ddr_len != '0);
  assign push     = pend_q;
  assign pop      = app_wdf_wren && app_wdf_rdy;
  assign cmd_fire = app_en && app_rdy;

  // Buffer slots committed for next cycle. Crediting the pop lets a beat be requested every
  // cycle while the MIG drains, without ever exceeding the two entries.
  assign fill = occ_q + {1'b0, pend_q} - {1'b0, pop};

  assign idle         = (state_q == StIdle);
  assign app_cmd      = '0;
  assign app_wdf_mask = '0;
  assign app_en       = run && init_calib_complete && (cmd_cnt_q < len_q);
  assign app_addr     = base_q + APP_ADDR_WIDTH'({cmd_cnt_q, 3'b000});
  assign wr_fifo_req  = run && init_calib_complete && !wr_fifo_empty &&
                        (req_cnt_q < len_q) && (fill < 2'd2);
  assign app_wdf_wren = (occ_q != 2'd0);
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = buf_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    base_d    = base_q;
    req_cnt_d = req_cnt_q;
    cmd_cnt_d = cmd_cnt_q;
    dat_cnt_d = dat_cnt_q;
    pend_d    = wr_fifo_req;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    occ_d     = occ_q + {1'b0, push} - {1'b0, pop};

    if (push)        wr_ptr_d  = ~wr_ptr_q;
    if (pop)         rd_ptr_d  = ~rd_ptr_q;
    if (wr_fifo_req) req_cnt_d = req_cnt_q + SINGLE_LEN'(1);
    if (cmd_fire)    cmd_cnt_d = cmd_cnt_q + SINGLE_LEN'(1);
    if (pop)         dat_cnt_d = dat_cnt_q + SINGLE_LEN'(1);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          len_d     = ddr_len;
          // Byte address to MIG word address, aligned to one 8-word burst.
          base_d    = APP_ADDR_WIDTH'(ddr_st_addr >> 3) & ~APP_ADDR_WIDTH'(7);
          req_cnt_d = '0;
          cmd_cnt_d = '0;
          dat_cnt_d = '0;
          rd_ptr_d  = 1'b0;
          wr_ptr_d  = 1'b0;
          occ_d     = 2'd0;
        end
      end
      StRun: begin
        if ((cmd_cnt_q == len_q) && (dat_cnt_q == len_q)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      base_q    <= '0;
      req_cnt_q <= '0;
      cmd_cnt_q <= '0;
      dat_cnt_q <= '0;
      pend_q    <= 1'b0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      base_q    <= base_d;
      req_cnt_q <= req_cnt_d;
      cmd_cnt_q <= cmd_cnt_d;
      dat_cnt_q <= dat_cnt_d;
      pend_q    <= pend_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      occ_q     <= occ_d;
      if (push) buf_q[wr_ptr_q] <= wr_fifo_data;
    end
  end

endmodule

// File: tb/tb_ddr_write_ctrl.sv
// Directed bench for ddr_write_ctrl: a FIFO model feeds numbered beats, a negedge monitor logs
// every accepted command address, accepted data beat and FIFO read, and the initial block
// compares those logs against hand-computed addresses and beat order.
module tb_ddr_write_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         conf;
  logic [31:0]  ddr_st_addr;
  logic [23:0]  ddr_len;
  logic         idle;
  logic         wr_fifo_empty;
  logic         wr_fifo_req;
  logic [511:0] wr_fifo_data = '0;
  logic         init_calib_complete;
  logic         app_rdy;
  logic         app_wdf_rdy;
  logic [2:0]   app_cmd;
  logic [28:0]  app_addr;
  logic         app_en;
  logic [63:0]  app_wdf_mask;
  logic [511:0] app_wdf_data;
  logic         app_wdf_end;
  logic         app_wdf_wren;

  ddr_write_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .conf                (conf),
    .ddr_st_addr         (ddr_st_addr),
    .ddr_len             (ddr_len),
    .idle                (idle),
    .wr_fifo_empty       (wr_fifo_empty),
    .wr_fifo_req         (wr_fifo_req),
    .wr_fifo_data        (wr_fifo_data),
    .init_calib_complete (init_calib_complete),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_en              (app_en),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_wren        (app_wdf_wren)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] beat(input int k);
    return {16{32'hC0DE0000 + 32'(k)}};
  endfunction

  // Upstream FIFO model; gap_mode forces empty on alternate cycles.
  logic [511:0] fifo_mem [64];
  int           fifo_wr  = 0;
  int           fifo_rd  = 0;
  logic         gap_mode = 1'b0;
  logic         phase    = 1'b0;

  assign wr_fifo_empty = (fifo_rd == fifo_wr) || (gap_mode && phase);

  always @(posedge clk) begin
    phase <= ~phase;
    if (wr_fifo_req) begin
      wr_fifo_data <= fifo_mem[fifo_rd];
      fifo_rd      <= fifo_rd + 1;
    end
  end

  // Monitor: values are stable mid-cycle and are what the next rising edge will see.
  logic [28:0]  cmd_log [64];
  logic [511:0] dat_log [64];
  int cmd_n = 0, dat_n = 0, req_n = 0, req_empty_n = 0, side_bad_n = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (app_en && app_rdy && cmd_n < 64) begin
        cmd_log[cmd_n] <= app_addr;
        cmd_n          <= cmd_n + 1;
      end
      if (app_wdf_wren && app_wdf_rdy && dat_n < 64) begin
        dat_log[dat_n] <= app_wdf_data;
        dat_n          <= dat_n + 1;
      end
      if (wr_fifo_req) req_n <= req_n + 1;
      if (wr_fifo_req && wr_fifo_empty) req_empty_n <= req_empty_n + 1;
      if (app_wdf_end !== app_wdf_wren || app_cmd !== 3'b000 || app_wdf_mask !== '0)
        side_bad_n <= side_bad_n + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[fifo_wr] = beat(fifo_wr);
      fifo_wr++;
    end
  endtask

  task automatic start(input logic [31:0] addr, input logic [23:0] len);
    conf        = 1'b1;
    ddr_st_addr = addr;
    ddr_len     = len;
    tick(1);
    conf        = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (!idle && i < 200) begin
      tick(1);
      i++;
    end
    check(tag, 512'(idle), 512'(1));
  endtask

  task automatic check_cmds(input string tag, input int c0, input int n, input int base);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_addr%0d", tag, i), 512'(cmd_log[c0 + i]), 512'(base + 8 * i));
  endtask

  task automatic check_data(input string tag, input int d0, input int b0, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_data%0d", tag, i), dat_log[d0 + i], beat(b0 + i));
  endtask

  int c0, d0, r0, b0;

  initial begin
    rst_n = 1'b0; conf = 1'b0; ddr_st_addr = '0; ddr_len = '0;
    init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    tick(3);
    check("rst_idle", 512'(idle), 512'(1));
    check("rst_req", 512'(wr_fifo_req), 512'(0));
    check("rst_en", 512'(app_en), 512'(0));
    check("rst_wren", 512'(app_wdf_wren), 512'(0));
    check("rst_end", 512'(app_wdf_end), 512'(0));
    check("rst_addr", 512'(app_addr), 512'(0));
    check("rst_data", app_wdf_data, 512'(0));
    check("rst_cmd", 512'(app_cmd), 512'(0));
    check("rst_mask", 512'(app_wdf_mask), 512'(0));
    rst_n = 1'b1;
    tick(2);

    // 1: always ready
    c0 = cmd_n; d0 = dat_n; r0 = req_n; b0 = fifo_wr;
    load(4);
    start(32'h1000, 24'd4);
    check("t1_busy", 512'(idle), 512'(0));
    wait_idle("t1_done");
    check("t1_ncmd", 512'(cmd_n - c0), 512'(4));
    check("t1_ndat", 512'(dat_n - d0), 512'(4));
    check("t1_nreq", 512'(req_n - r0), 512'(4));
    check_cmds("t1", c0, 4, 'h200);
    check_data("t1", d0, b0, 4);

    // 2: write-data stall
    c0 = cmd_n; d0 = dat_n; r0 = req_n; b0 = fifo_wr;
    app_wdf_rdy = 1'b0;
    load(3);
    start(32'h3000, 24'd3);
    tick(8);
    check("t2_stall_nreq", 512'(req_n - r0), 512'(2));
    check("t2_stall_ndat", 512'(dat_n - d0), 512'(0));
    check("t2_stall_ncmd", 512'(cmd_n - c0), 512'(3));
    check("t2_stall_wren", 512'(app_wdf_wren), 512'(1));
    check("t2_stall_head", app_wdf_data, beat(b0));
    app_wdf_rdy = 1'b1;
    wait_idle("t2_done");
    check("t2_nreq", 512'(req_n - r0), 512'(3));
    check("t2_ndat", 512'(dat_n - d0), 512'(3));
    check_cmds("t2", c0, 3, 'h600);
    check_data("t2", d0, b0, 3);

    // 3: command stall, unaligned low address bits ignored
    c0 = cmd_n; d0 = dat_n; r0 = req_n; b0 = fifo_wr;
    app_rdy = 1'b0;
    load(2);
    start(32'h4075, 24'd2);
    check("t3_en_early", 512'(app_en), 512'(1));
    check("t3_addr_early", 512'(app_addr), 512'('h808));
    tick(5);
    check("t3_en_held", 512'(app_en), 512'(1));
    check("t3_addr_held", 512'(app_addr), 512'('h808));
    check("t3_ndat_first", 512'(dat_n - d0), 512'(2));
    check("t3_ncmd_none", 512'(cmd_n - c0), 512'(0));
    app_rdy = 1'b1;
    wait_idle("t3_done");
    check("t3_ncmd", 512'(cmd_n - c0), 512'(2));
    check_cmds("t3", c0, 2, 'h808);
    check_data("t3", d0, b0, 2);

    // 4: sparse source
    c0 = cmd_n; d0 = dat_n; r0 = req_n; b0 = fifo_wr;
    gap_mode = 1'b1;
    load(5);
    start(32'h0, 24'd5);
    wait_idle("t4_done");
    gap_mode = 1'b0;
    check("t4_nreq", 512'(req_n - r0), 512'(5));
    check("t4_ndat", 512'(dat_n - d0), 512'(5));
    check("t4_ncmd", 512'(cmd_n - c0), 512'(5));
    check("t4_req_empty", 512'(req_empty_n), 512'(0));
    check_cmds("t4", c0, 5, 0);
    check_data("t4", d0, b0, 5);

    // 5a: zero length is ignored
    c0 = cmd_n; r0 = req_n;
    start(32'h100, 24'd0);
    tick(3);
    check("t5_zero_idle", 512'(idle), 512'(1));
    check("t5_zero_en", 512'(app_en), 512'(0));
    check("t5_zero_nreq", 512'(req_n - r0), 512'(0));
    check("t5_zero_ncmd", 512'(cmd_n - c0), 512'(0));

    // 5b: conf mid-transfer is ignored
    c0 = cmd_n; d0 = dat_n; r0 = req_n; b0 = fifo_wr;
    load(3);
    start(32'h2000, 24'd3);
    tick(1);
    start(32'h8000, 24'd5);
    wait_idle("t5_done");
    tick(3);
    check("t5_stay_idle", 512'(idle), 512'(1));
    check("t5_nreq", 512'(req_n - r0), 512'(3));
    check("t5_ncmd", 512'(cmd_n - c0), 512'(3));
    check_cmds("t5", c0, 3, 'h400);
    check_data("t5", d0, b0, 3);

    // 6a: calibration gates activity
    c0 = cmd_n; d0 = dat_n; r0 = req_n; b0 = fifo_wr;
    init_calib_complete = 1'b0;
    load(2);
    start(32'h0, 24'd2);
    tick(5);
    check("t6_cal_busy", 512'(idle), 512'(0));
    check("t6_cal_en", 512'(app_en), 512'(0));
    check("t6_cal_req", 512'(wr_fifo_req), 512'(0));
    check("t6_cal_nreq", 512'(req_n - r0), 512'(0));
    init_calib_complete = 1'b1;
    wait_idle("t6_cal_done");
    check("t6_cal_ncmd", 512'(cmd_n - c0), 512'(2));
    check_data("t6_cal", d0, b0, 2);

    // 6b: asynchronous reset mid-transfer
    load(4);
    start(32'h40, 24'd4);
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_idle", 512'(idle), 512'(1));
    check("t6_rst_en", 512'(app_en), 512'(0));
    check("t6_rst_req", 512'(wr_fifo_req), 512'(0));
    check("t6_rst_wren", 512'(app_wdf_wren), 512'(0));
    check("t6_rst_addr", 512'(app_addr), 512'(0));
    check("t6_rst_data", app_wdf_data, 512'(0));
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("t6_post_idle", 512'(idle), 512'(1));
    check("t6_post_en", 512'(app_en), 512'(0));

    check("side_channels", 512'(side_bad_n), 512'(0));
    check("req_while_empty", 512'(req_empty_n), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
